// File: rtl/pe_reducer_sched_if.sv
// Signal bundle joining the job sequencer to its job source, the sparse-entry
// buffer and the PEReducer. The slave modport is the sequencer's view; the
// master modport is the view of whatever surrounds it.
interface pe_reducer_sched_if #(
  parameter int N_MAX  = 64,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  localparam int IDX_W = $clog2(N_MAX);
  localparam int LEN_W = 7;

  logic                  i_job_valid;
  logic [LEN_W-1:0]      i_job_len;
  logic                  o_job_ready;
  logic                  o_rd_en;
  logic [IDX_W-1:0]      o_rd_idx;
  logic [3*ADDR_W-1:0]   i_rd_addr;
  logic [DATA_W-1:0]     i_rd_w;
  logic [DATA_W-1:0]     i_rd_ia;
  logic [9*ADDR_W-1:0]   o_pe_addr;
  logic [3*DATA_W-1:0]   o_pe_w;
  logic [3*DATA_W-1:0]   o_pe_ia;
  logic                  o_pe_start;
  logic                  i_pe_finish;
  logic                  o_busy;
  logic                  o_done;
  logic [IDX_W-1:0]      o_groups;
  logic                  o_err;

  modport slave (
    input  i_job_valid, i_job_len,
    output o_job_ready,
    output o_rd_en, o_rd_idx,
    input  i_rd_addr, i_rd_w, i_rd_ia,
    output o_pe_addr, o_pe_w, o_pe_ia, o_pe_start,
    input  i_pe_finish,
    output o_busy, o_done, o_groups, o_err
  );

  modport master (
    output i_job_valid, i_job_len,
    input  o_job_ready,
    input  o_rd_en, o_rd_idx,
    output i_rd_addr, i_rd_w, i_rd_ia,
    input  o_pe_addr, o_pe_w, o_pe_ia, o_pe_start,
    output i_pe_finish,
    input  o_busy, o_done, o_groups, o_err
  );
endinterface

// File: rtl/pe_reducer_sched.sv
// Job sequencer for PEReducer: reads a job's sparse entries from the entry
// buffer three at a time, loads them into three slots, fires a start pulse and
// waits for PEReducer to finish before fetching the next group. Short final
// groups are padded with zero-weight copies of the last real entry so that
// PEReducer merges the pads into that entry without changing its sum.
module pe_reducer_sched #(
  parameter int N_MAX   = 64,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input logic               i_clk,
  input logic               i_rst_n,
  pe_reducer_sched_if.slave bus
);
  localparam int IDX_W  = $clog2(N_MAX);
  localparam int LEN_W  = 7;
  localparam int CRD_W  = 3 * ADDR_W;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0]  N_MAX_L   = LEN_W'(N_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CAPT  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [1:0]         k_q, k_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [IDX_W-1:0]   groups_q, groups_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic [CRD_W-1:0]   slot_addr_q [3];
  logic [CRD_W-1:0]   slot_addr_d [3];
  logic [DATA_W-1:0]  slot_w_q [3];
  logic [DATA_W-1:0]  slot_w_d [3];
  logic [DATA_W-1:0]  slot_ia_q [3];
  logic [DATA_W-1:0]  slot_ia_d [3];

  logic [1:0]         grp_n;
  logic [1:0]         last_k;
  logic               rd_en_c;
  logic [IDX_W-1:0]   rd_idx_c;
  logic               start_c;
  logic               done_c;

  // Size of the current group (min(3, rem)) and the read index of its last entry.
  always_comb begin
    grp_n  = (rem_q >= LEN_W'(3)) ? 2'd3 : rem_q[1:0];
    last_k = grp_n - 2'd1;
  end

  // Next-state, counter and slot-capture logic for the job sequencer.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    k_d         = k_q;
    wait_d      = wait_q;
    groups_d    = groups_q;
    err_d       = err_q;
    slot_addr_d = slot_addr_q;
    slot_w_d    = slot_w_q;
    slot_ia_d   = slot_ia_q;
    rd_en_c     = 1'b0;
    rd_idx_c    = '0;
    start_c     = 1'b0;
    done_c      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_job_valid && ready_q) begin
          rem_d    = bus.i_job_len;
          idx_d    = '0;
          k_d      = 2'd0;
          groups_d = '0;
          err_d    = 1'b0;
          if (bus.i_job_len == '0) begin
            state_d = S_DONE;
          end else if (bus.i_job_len > N_MAX_L) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        rd_en_c  = 1'b1;
        rd_idx_c = IDX_W'(idx_q + LEN_W'(k_q));
        for (int s = 0; s < 3; s++) begin
          if ((k_q != 2'd0) && (2'(s) == (k_q - 2'd1))) begin
            slot_addr_d[s] = bus.i_rd_addr;
            slot_w_d[s]    = bus.i_rd_w;
            slot_ia_d[s]   = bus.i_rd_ia;
          end
        end
        if (k_q == last_k) begin
          state_d = S_CAPT;
        end else begin
          k_d = k_q + 2'd1;
        end
      end

      S_CAPT: begin
        for (int s = 0; s < 3; s++) begin
          if (2'(s) == last_k) begin
            slot_addr_d[s] = bus.i_rd_addr;
            slot_w_d[s]    = bus.i_rd_w;
            slot_ia_d[s]   = bus.i_rd_ia;
          end else if (2'(s) > last_k) begin
            slot_addr_d[s] = bus.i_rd_addr;
            slot_w_d[s]    = '0;
            slot_ia_d[s]   = '0;
          end
        end
        idx_d   = idx_q + LEN_W'(grp_n);
        rem_d   = rem_q - LEN_W'(grp_n);
        k_d     = 2'd0;
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        start_c  = 1'b1;
        groups_d = groups_q + IDX_W'(1);
        wait_d   = '0;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        if (bus.i_pe_finish) begin
          state_d = (rem_q != '0) ? S_FETCH : S_DONE;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State, counters, status and slot registers; reset aborts any job in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      idx_q    <= '0;
      k_q      <= 2'd0;
      wait_q   <= '0;
      groups_q <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      for (int s = 0; s < 3; s++) begin
        slot_addr_q[s] <= '0;
        slot_w_q[s]    <= '0;
        slot_ia_q[s]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      wait_q      <= wait_d;
      groups_q    <= groups_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      slot_addr_q <= slot_addr_d;
      slot_w_q    <= slot_w_d;
      slot_ia_q   <= slot_ia_d;
    end
  end

  // Slots are packed with slot 0 in the least-significant position.
  always_comb begin
    bus.o_pe_addr = {slot_addr_q[2], slot_addr_q[1], slot_addr_q[0]};
    bus.o_pe_w    = {slot_w_q[2], slot_w_q[1], slot_w_q[0]};
    bus.o_pe_ia   = {slot_ia_q[2], slot_ia_q[1], slot_ia_q[0]};
  end

  // Status and strobe outputs; ready is registered so it stays low while in reset.
  always_comb begin
    bus.o_job_ready = ready_q;
    bus.o_busy      = (state_q != S_IDLE);
    bus.o_rd_en     = rd_en_c;
    bus.o_rd_idx    = rd_idx_c;
    bus.o_pe_start  = start_c;
    bus.o_done      = done_c;
    bus.o_groups    = groups_q;
    bus.o_err       = err_q;
  end

endmodule
